ps2_host_tx: RTL and testbench

//  PS/2 host-to-device transmitter; companion of the PS/2 keyboard receiver on the same pins.

---
 rtl/ps2_pkg.sv | 19 +
 rtl/ps2_sync_edge.sv | 21 ++
 rtl/ps2_host_tx.sv | 119 +++++++++++
 tb/tb_ps2_host_tx.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types, frame constants and parity helper
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    SEND,
    ACK,
    WAIT_REL,
    DONE
  } ps2_tx_state_t;

  localparam int PS2_FRAME_BITS = 11;

  function automatic logic ps2_odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// rtl/ps2_sync_edge.sv - 3-flop synchroniser with falling-edge pulse for a PS/2 pad
module ps2_sync_edge (
  input  logic clk,
  input  logic resetn,
  input  logic pad,
  output logic level,
  output logic fall
);

  logic [2:0] s;

  // Reset to all-ones: an idle PS/2 line is pulled high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) s <= 3'b111;
    else         s <= {s[1:0], pad};
  end

  assign level = s[1];
  assign fall  = s[2] & ~s[1];

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter, open-drain clk/data
// Optional watchdog: define PS2_TX_TIMEOUT_EN.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 5000
`ifdef PS2_TX_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int CW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);

  ps2_tx_state_t state_q, state_d;

  logic [PS2_FRAME_BITS-1:0] frame_q;
  logic [3:0]                bitcnt_q;
  logic [CW-1:0]             inh_q;
  logic                      err_q;
  logic [1:0]                dsync_q;
  logic                      clk_s, clk_fall, data_s;
  logic                      accept, inh_last, wd_expire;

  ps2_sync_edge u_clk_sync (
    .clk    (clk),
    .resetn (resetn),
    .pad    (ps2_clk_in),
    .level  (clk_s),
    .fall   (clk_fall)
  );

  assign data_s   = dsync_q[1];
  assign accept   = tx_valid && (state_q == IDLE);
  assign inh_last = (state_q == INHIBIT) && (inh_q == INH_LAST);

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WW-1:0] wd_q;
  logic          wd_active;

  assign wd_active = (state_q == SEND) || (state_q == ACK) || (state_q == WAIT_REL);
  assign wd_expire = wd_active && (wd_q == WW'(TIMEOUT_CYCLES - 1));

  // Restarts on every device clock fall, so it bounds the gap between bits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                    wd_q <= '0;
    else if (!wd_active || clk_fall) wd_q <= '0;
    else                            wd_q <= wd_q + 1'b1;
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (tx_valid)                       state_d = INHIBIT;
      INHIBIT:  if (inh_last)                       state_d = SEND;
      SEND:     if (clk_fall && bitcnt_q == 4'd9)   state_d = ACK;
      ACK:      if (clk_fall)                       state_d = WAIT_REL;
      WAIT_REL: if (clk_s && data_s)                state_d = DONE;
      DONE:                                         state_d = IDLE;
      default:                                      state_d = IDLE;
    endcase
    if (wd_expire) state_d = DONE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_q  <= '0;
      bitcnt_q <= '0;
      inh_q    <= '0;
      err_q    <= 1'b0;
      dsync_q  <= 2'b11;
    end else begin
      dsync_q <= {dsync_q[0], ps2_data_in};
      if (accept) begin
        frame_q  <= {1'b1, ps2_odd_parity(tx_data), tx_data, 1'b0};
        bitcnt_q <= '0;
        err_q    <= 1'b0;
      end
      if (state_q == INHIBIT) inh_q <= inh_q + 1'b1;
      else                    inh_q <= '0;
      if (clk_fall && (state_q == SEND || state_q == ACK) && bitcnt_q != 4'd11)
        bitcnt_q <= bitcnt_q + 4'd1;
      // Device ACK is an active-low data bit during the eleventh clock.
      if (state_q == ACK && clk_fall) err_q <= data_s;
      if (wd_expire)                  err_q <= 1'b1;
    end
  end

  assign tx_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign tx_done     = (state_q == DONE);
  assign tx_err      = (state_q == DONE) && err_q;
  assign ps2_clk_oe  = (state_q == INHIBIT);
  assign ps2_data_oe = inh_last || ((state_q == SEND) && !frame_q[bitcnt_q]);

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench for ps2_host_tx with open-drain device model
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int H   = 8;
  localparam int TO  = 200;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err, busy;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic       clk_line, data_line;

  assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign data_line = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH)
`ifdef PS2_TX_TIMEOUT_EN
    , .TIMEOUT_CYCLES (TO)
`endif
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .busy        (busy),
    .ps2_clk_in  (clk_line),
    .ps2_data_in (data_line),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  typedef struct {
    logic [10:0] frame;
    logic        err;
    logic        chk;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  int          dev_falls = 0;
  logic        dev_busy = 1'b0;
  logic        dev_ack = 1'b1;
  logic        dev_silent = 1'b0;
  logic [10:0] cap_frame = '0;

  logic [7:0]  vd[5] = '{8'hED, 8'hF4, 8'h01, 8'h00, 8'hF4};
  logic [10:0] vf[5] = '{11'b11111011010, 11'b10111101000, 11'b10000000010,
                         11'b11000000000, 11'b10111101000};
  logic        va[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [10:0] f, input logic e, input logic c);
    exp_t x;
    x.frame = f;
    x.err   = e;
    x.chk   = c;
    exp_q.push_back(x);
  endtask

  // Device model: answers a request-to-send with 11 clocks, samples on each rise.
  initial begin
    logic [10:0] cap;
    forever begin
      dev_busy = 1'b0;
      wait (ps2_clk_oe);
      wait (!ps2_clk_oe);
      dev_busy = 1'b1;
      repeat (H) @(negedge clk);
      cap[0] = data_line;
      if (!dev_silent) begin
        for (int i = 1; i <= 10; i++) begin
          dev_clk_low = 1'b1;
          dev_falls++;
          repeat (H) @(negedge clk);
          dev_clk_low = 1'b0;
          cap[i] = data_line;
          repeat (H) @(negedge clk);
        end
        cap_frame = cap;
        if (dev_ack) dev_data_low = 1'b1;
        repeat (2) @(negedge clk);
        dev_clk_low = 1'b1;
        dev_falls++;
        repeat (H) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (2) @(negedge clk);
        dev_data_low = 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && tx_done) begin
        check("exp_queue_empty", 32'(exp_q.size() == 0), 0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("tx_err", 32'(tx_err), 32'(e.err));
          if (e.chk) check("line_frame", 32'(cap_frame), 32'(e.frame));
        end
        done_cnt++;
        @(negedge clk);
        check("done_width", 32'(tx_done), 0);
        check("ready_after_done", 32'(tx_ready), 1);
      end
    end
  end

  initial begin
    int hi = 0;
    int dhi = 0;
    forever begin
      @(negedge clk);
      if (ps2_clk_oe) begin
        hi++;
        if (ps2_data_oe) dhi++;
      end else if (hi != 0) begin
        check("inhibit_len", 32'(hi), 32'(INH));
        check("start_lead", 32'(dhi), 1);
        hi = 0;
        dhi = 0;
      end
    end
  end

  task automatic drive_accept(input logic [7:0] d);
    int t = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("accept_wait", 32'(tx_ready), 1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int t = 0;
    while (done_cnt < n && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", 32'(done_cnt >= n), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic [10:0] f, input logic ack);
    int n = done_cnt;
    dev_ack = ack;
    push_exp(f, !ack, 1'b1);
    drive_accept(d);
    wait_done(n + 1);
    dev_ack = 1'b1;
  endtask

  initial begin
    int t;
    int n;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(tx_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_clk_oe", 32'(ps2_clk_oe), 0);
    check("rst_data_oe", 32'(ps2_data_oe), 0);
    check("rst_done", 32'({tx_done, tx_err}), 0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 5; i++) send(vd[i], vf[i], va[i]);

    // Reset in the middle of a frame, after the fifth device clock.
    n = dev_falls;
    drive_accept(8'hED);
    t = 0;
    while (dev_falls < n + 5 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check("reached_fall5", 32'(dev_falls >= n + 5), 1);
    repeat (5) @(negedge clk);
    check("pre_reset_data_oe", 32'(ps2_data_oe), 1);
    resetn = 1'b0;
    #1;
    check("mid_rst_clk_oe", 32'(ps2_clk_oe), 0);
    check("mid_rst_data_oe", 32'(ps2_data_oe), 0);
    check("mid_rst_busy", 32'(busy), 0);
    @(negedge clk);
    resetn = 1'b1;
    t = 0;
    while (dev_busy && t < 5000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    send(8'hED, 11'b11111011010, 1'b1);

    // Back-to-back: 0xAA offered while busy must be dropped, 0x55 taken at DONE.
    n = done_cnt;
    push_exp(11'b11000100100, 1'b0, 1'b1);
    push_exp(11'b11010101010, 1'b0, 1'b1);
    tx_data  = 8'h12;
    tx_valid = 1'b1;
    t = 0;
    while (!tx_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    tx_data = 8'hAA;
    t = 0;
    while (!tx_done && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("b2b_first_done", 32'(tx_done), 1);
    tx_data = 8'h55;
    @(negedge clk);
    check("b2b_idle_ready", 32'(tx_ready), 1);
    @(negedge clk);
    check("b2b_start", 32'(ps2_clk_oe), 1);
    tx_valid = 1'b0;
    wait_done(n + 2);

`ifdef PS2_TX_TIMEOUT_EN
    dev_silent = 1'b1;
    n = done_cnt;
    push_exp(11'b0, 1'b1, 1'b0);
    drive_accept(8'h3C);
    t = 0;
    while (ps2_clk_oe && t < 2000) begin
      @(negedge clk);
      t++;
    end
    t = 0;
    while (!tx_done && t < TO + 50) begin
      @(negedge clk);
      t++;
    end
    check("timeout_len", 32'(t), 32'(TO));
    check("timeout_clk_oe", 32'(ps2_clk_oe), 0);
    check("timeout_data_oe", 32'(ps2_data_oe), 0);
    wait_done(n + 1);
    dev_silent = 1'b0;
`endif

    check("leftover_expect", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck, want finish");
    $fatal(1);
  end

endmodule
